// File: rtl/score_argmax.sv
// Streaming arg-max over NUM_CLASSES signed scores. The result is held until the consumer takes it.
// Define SCORE_MARGIN_EN to add second-best tracking and the margin output.
module score_argmax #(
  parameter int NUM_CLASSES = 10,
  parameter int DATA_W      = 32
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           start,
  input  logic                           score_vld,
  input  logic signed [DATA_W-1:0]       score,
  output logic                           score_rdy,
  output logic                           result_vld,
  input  logic                           result_rdy,
  output logic [$clog2(NUM_CLASSES)-1:0] result_idx,
  output logic signed [DATA_W-1:0]       result_score,
  output logic                           busy
`ifdef SCORE_MARGIN_EN
  ,
  output logic [DATA_W-1:0]              margin
`endif
);

  localparam int IDX_W = $clog2(NUM_CLASSES);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t                   state;
  logic [IDX_W-1:0]         cnt;
  logic signed [DATA_W-1:0] best;
  logic signed [DATA_W-1:0] best_n;
  logic [IDX_W-1:0]         best_idx;
  logic [IDX_W-1:0]         best_idx_n;
  logic                     beat;
  logic                     last_beat;

  // score_rdy is a state-decoded flop, so acceptance never depends combinationally on inputs.
  assign beat      = score_vld & score_rdy;
  assign last_beat = (cnt == IDX_W'(NUM_CLASSES - 1));

`ifdef SCORE_MARGIN_EN
  localparam logic signed [DATA_W-1:0] SCORE_MIN = {1'b1, {(DATA_W-1){1'b0}}};

  logic signed [DATA_W-1:0] second;
  logic signed [DATA_W-1:0] second_n;
  logic [DATA_W-1:0]        margin_n;

  always_comb begin
    best_n     = best;
    best_idx_n = best_idx;
    second_n   = second;
    if (cnt == '0) begin
      best_n     = score;
      best_idx_n = '0;
      second_n   = SCORE_MIN;
    end else if (score > best) begin
      second_n   = best;
      best_n     = score;
      best_idx_n = cnt;
    end else if (score > second) begin
      second_n   = score;
    end
    margin_n = best_n - second_n;
  end
`else
  always_comb begin
    best_n     = best;
    best_idx_n = best_idx;
    if (cnt == '0) begin
      best_n     = score;
      best_idx_n = '0;
    end else if (score > best) begin
      // Strict compare: on a tie the earlier (lower) index stays.
      best_n     = score;
      best_idx_n = cnt;
    end
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      cnt          <= '0;
      best         <= '0;
      best_idx     <= '0;
      score_rdy    <= 1'b0;
      result_vld   <= 1'b0;
      result_idx   <= '0;
      result_score <= '0;
      busy         <= 1'b0;
`ifdef SCORE_MARGIN_EN
      second       <= '0;
      margin       <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state     <= ACCUM;
            cnt       <= '0;
            score_rdy <= 1'b1;
            busy      <= 1'b1;
          end
        end

        ACCUM: begin
          // A restart discards the partial run and also drops a beat presented alongside it.
          if (start) begin
            cnt <= '0;
          end else if (beat) begin
            best     <= best_n;
            best_idx <= best_idx_n;
            cnt      <= cnt + IDX_W'(1);
`ifdef SCORE_MARGIN_EN
            second   <= second_n;
`endif
            if (last_beat) begin
              state        <= DONE;
              score_rdy    <= 1'b0;
              result_vld   <= 1'b1;
              result_idx   <= best_idx_n;
              result_score <= best_n;
`ifdef SCORE_MARGIN_EN
              margin       <= margin_n;
`endif
            end
          end
        end

        DONE: begin
          // Result fields are left untouched on hand-off; only result_vld drops.
          if (result_rdy) begin
            result_vld <= 1'b0;
            if (start) begin
              state     <= ACCUM;
              cnt       <= '0;
              score_rdy <= 1'b1;
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end
        end

        default: begin
          state      <= IDLE;
          score_rdy  <= 1'b0;
          result_vld <= 1'b0;
          busy       <= 1'b0;
        end
      endcase
    end
  end

endmodule
